// File: rtl/ir_key_ctrl.sv
// ir_key_ctrl: NEC IR key-event sequencer (press / hold / release) feeding a FWFT event FIFO.
// Optional macro IR_ADDR_FILTER_EN: drop frames whose address differs from DEV_ADDR.
module ir_key_ctrl #(
    parameter int unsigned TIMEOUT_US = 120000,
    parameter int unsigned HOLD_RPTS  = 4,
    parameter int unsigned HOLD_RATE  = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  DEV_ADDR   = 8'h00
) (
    input  logic       clk_1m,
    input  logic       rst_n,
    input  logic       frame_stb,
    input  logic [7:0] frame_addr,
    input  logic [7:0] frame_cmd,
    input  logic [7:0] frame_cmd_n,
    input  logic       rpt_stb,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic [1:0] evt_type,
    input  logic       evt_ready,
    output logic [2:0] fifo_level,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic [7:0] err_cnt,
    output logic       key_down
);

    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW      = $clog2(TIMEOUT_US + 1);
    localparam int unsigned RPT_MAX = (HOLD_RPTS > HOLD_RATE) ? HOLD_RPTS : HOLD_RATE;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_HOLD    = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cur_code_q, cur_code_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic            pend_press_q, pend_press_d;
    logic [7:0]      pend_code_q, pend_code_d;
    logic            skid_vld_q, skid_frame_q;
    logic [7:0]      skid_code_q;
    logic            key_down_q;
    logic            overflow_q;
    logic [7:0]      err_cnt_q;

    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            addr_ok, cmd_ok, frame_ok, bad_frame;
    logic            live_frame, live_rpt, skid_vld_d;
    logic            ev_frame, ev_rpt;
    logic [7:0]      ev_code;
    logic            hit, change, timeout;
    logic [RW-1:0]   rpt_inc, rpt_lim;
    logic            push_en;
    logic [1:0]      push_type;
    logic [7:0]      push_code;
    logic            fifo_full, pop, wr_ok, drop;
    logic [9:0]      head;

`ifdef IR_ADDR_FILTER_EN
    assign addr_ok = (frame_addr == DEV_ADDR);
`else
    logic unused_addr;
    assign unused_addr = ^(frame_addr ^ DEV_ADDR);
    assign addr_ok     = 1'b1;
`endif

    assign frame_ok   = frame_stb && addr_ok;
    assign cmd_ok     = (frame_cmd == ~frame_cmd_n);
    assign bad_frame  = frame_ok && !cmd_ok;
    assign live_frame = frame_ok && cmd_ok;
    assign live_rpt   = rpt_stb && !frame_stb;

    // Arrivals during the pend_press cycle park in the skid; while the skid drains,
    // a concurrent live arrival is lost (frames are milliseconds apart in practice).
    assign skid_vld_d = pend_press_q && (live_frame || live_rpt);

    always_comb begin
        ev_frame = 1'b0;
        ev_rpt   = 1'b0;
        ev_code  = frame_cmd;
        if (pend_press_q) begin
            ev_frame = 1'b0;
        end else if (skid_vld_q) begin
            ev_frame = skid_frame_q;
            ev_rpt   = !skid_frame_q;
            ev_code  = skid_code_q;
        end else begin
            ev_frame = live_frame;
            ev_rpt   = live_rpt;
        end
    end

    assign hit     = ev_rpt || (ev_frame && (ev_code == cur_code_q));
    assign change  = ev_frame && (ev_code != cur_code_q);
    assign timeout = (timer_q == TW'(TIMEOUT_US - 1));
    assign rpt_inc = rpt_cnt_q + RW'(1);
    assign rpt_lim = (state_q == S_HOLD) ? RW'(HOLD_RATE) : RW'(HOLD_RPTS);

    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ev_frame) state_d = S_PRESSED;
            end
            S_PRESSED, S_HOLD: begin
                if (pend_press_q) begin
                    state_d = S_PRESSED;
                end else if (change) begin
                    state_d = S_PRESSED;
                end else if (hit) begin
                    if (state_q == S_PRESSED && rpt_inc == rpt_lim) state_d = S_HOLD;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push_en      = 1'b0;
        push_type    = EV_PRESS;
        push_code    = cur_code_q;
        cur_code_d   = cur_code_q;
        rpt_cnt_d    = rpt_cnt_q;
        timer_d      = (state_q == S_IDLE) ? '0 : timer_q + TW'(1);
        pend_press_d = 1'b0;
        pend_code_d  = pend_code_q;
        case (state_q)
            S_IDLE: begin
                if (ev_frame) begin
                    push_en    = 1'b1;
                    push_type  = EV_PRESS;
                    push_code  = ev_code;
                    cur_code_d = ev_code;
                    rpt_cnt_d  = '0;
                    timer_d    = '0;
                end
            end
            S_PRESSED, S_HOLD: begin
                if (pend_press_q) begin
                    push_en    = 1'b1;
                    push_type  = EV_PRESS;
                    push_code  = pend_code_q;
                    cur_code_d = pend_code_q;
                    rpt_cnt_d  = '0;
                    timer_d    = '0;
                end else if (change) begin
                    push_en      = 1'b1;
                    push_type    = EV_RELEASE;
                    pend_press_d = 1'b1;
                    pend_code_d  = ev_code;
                    timer_d      = '0;
                end else if (hit) begin
                    timer_d = '0;
                    if (rpt_inc == rpt_lim) begin
                        push_en   = 1'b1;
                        push_type = EV_HOLD;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
                end else if (timeout) begin
                    push_en   = 1'b1;
                    push_type = EV_RELEASE;
                    timer_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            cur_code_q   <= '0;
            timer_q      <= '0;
            rpt_cnt_q    <= '0;
            pend_press_q <= 1'b0;
            pend_code_q  <= '0;
            skid_vld_q   <= 1'b0;
            skid_frame_q <= 1'b0;
            skid_code_q  <= '0;
            key_down_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            cur_code_q   <= cur_code_d;
            timer_q      <= timer_d;
            rpt_cnt_q    <= rpt_cnt_d;
            pend_press_q <= pend_press_d;
            pend_code_q  <= pend_code_d;
            skid_vld_q   <= skid_vld_d;
            skid_frame_q <= live_frame;
            skid_code_q  <= frame_cmd;
            key_down_q   <= (state_d != S_IDLE);
            if (bad_frame && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign wr_ok     = push_en && (!fifo_full || pop);
    assign drop      = push_en && fifo_full && !pop;

    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= {push_type, push_code};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? head[7:0] : '0;
    assign evt_type   = evt_valid ? head[9:8] : '0;
    assign fifo_level = 3'(count_q);
    assign overflow   = overflow_q;
    assign err_cnt    = err_cnt_q;
    assign key_down   = key_down_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// tb_ir_key_ctrl: directed and random stimulus against a timestamp/queue model of the key-event rules.
module tb_ir_key_ctrl;

    localparam int unsigned T_OUT   = 300;
    localparam int unsigned N_RPTS  = 4;
    localparam int unsigned N_RATE  = 2;
    localparam int unsigned DEPTH   = 4;
    localparam logic [7:0]  MY_ADDR = 8'h00;
    localparam logic [1:0]  E_PRESS = 2'b01;
    localparam logic [1:0]  E_HOLD  = 2'b10;
    localparam logic [1:0]  E_REL   = 2'b11;

    logic       clk_1m = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_stb = 1'b0;
    logic [7:0] frame_addr = '0;
    logic [7:0] frame_cmd = '0;
    logic [7:0] frame_cmd_n = '0;
    logic       rpt_stb = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic [1:0] evt_type;
    logic       evt_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic [7:0] err_cnt;
    logic       key_down;

    int n_checks = 0;
    int n_errors = 0;

    ir_key_ctrl #(
        .TIMEOUT_US(T_OUT),
        .HOLD_RPTS (N_RPTS),
        .HOLD_RATE (N_RATE),
        .FIFO_DEPTH(DEPTH),
        .DEV_ADDR  (MY_ADDR)
    ) dut (
        .clk_1m     (clk_1m),
        .rst_n      (rst_n),
        .frame_stb  (frame_stb),
        .frame_addr (frame_addr),
        .frame_cmd  (frame_cmd),
        .frame_cmd_n(frame_cmd_n),
        .rpt_stb    (rpt_stb),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_type   (evt_type),
        .evt_ready  (evt_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .err_cnt    (err_cnt),
        .key_down   (key_down)
    );

    always #5 clk_1m = ~clk_1m;

    // Reference model: key held or not, repeat tally, cycle stamp of last activity, event queue.
    logic [9:0]  mq[$];
    bit          m_ovf;
    int          m_err;
    int          m_mode;       // 0 released, 1 pressed, 2 holding
    logic [7:0]  m_code;
    int          m_reps;
    longint      m_cyc, m_last;
    bit          m_pend;
    logic [7:0]  m_pend_code;
    bit          m_skid, m_skid_frame;
    logic [7:0]  m_skid_code;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_err = 0; m_mode = 0; m_code = '0; m_reps = 0;
        m_cyc = 0; m_last = 0; m_pend = 0; m_pend_code = '0;
        m_skid = 0; m_skid_frame = 0; m_skid_code = '0;
    endtask

    task automatic model_step(input logic f, input logic [7:0] a, input logic [7:0] c,
                              input logic [7:0] cn, input logic r, input logic rdy, input logic clr);
        bit pop, addr_hit, arr_f, arr_r, have;
        logic [9:0] ev;
        logic [7:0] code;
        pop = (mq.size() != 0) && rdy;
        have = 0;
        ev = '0;
`ifdef IR_ADDR_FILTER_EN
        addr_hit = (a == MY_ADDR);
`else
        addr_hit = 1'b1;
`endif
        if (f && addr_hit && (c != ~cn) && m_err < 255) m_err++;
        arr_f = f && addr_hit && (c == ~cn);
        arr_r = r && !f;
        code = c;
        if (m_pend) begin
            have = 1; ev = {E_PRESS, m_pend_code};
            m_code = m_pend_code; m_reps = 0; m_last = m_cyc; m_pend = 0;
            if (arr_f || arr_r) begin
                m_skid = 1; m_skid_frame = arr_f; m_skid_code = c;
            end
        end else begin
            if (m_skid) begin
                arr_f = m_skid_frame; arr_r = !m_skid_frame; code = m_skid_code; m_skid = 0;
            end
            if (m_mode == 0) begin
                if (arr_f) begin
                    have = 1; ev = {E_PRESS, code};
                    m_code = code; m_reps = 0; m_last = m_cyc; m_mode = 1;
                end
            end else if (arr_f && code != m_code) begin
                have = 1; ev = {E_REL, m_code};
                m_pend = 1; m_pend_code = code; m_last = m_cyc; m_mode = 1;
            end else if (arr_f || arr_r) begin
                m_last = m_cyc;
                m_reps++;
                if (m_reps == ((m_mode == 2) ? N_RATE : N_RPTS)) begin
                    have = 1; ev = {E_HOLD, m_code}; m_reps = 0; m_mode = 2;
                end
            end else if (m_cyc - m_last == longint'(T_OUT)) begin
                have = 1; ev = {E_REL, m_code}; m_mode = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (have && mq.size() >= DEPTH) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (have && mq.size() < DEPTH) mq.push_back(ev);
        m_cyc++;
    endtask

    task automatic compare_all();
        check_eq("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("evt_code", 32'(evt_code), 32'(mq[0][7:0]));
            check_eq("evt_type", 32'(evt_type), 32'(mq[0][9:8]));
        end
        check_eq("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_err));
        check_eq("key_down", 32'(key_down), 32'(m_mode != 0));
    endtask

    // Called at a negedge: drive, model the coming posedge, then compare at the next negedge.
    task automatic cycle(input logic f, input logic [7:0] a, input logic [7:0] c,
                         input logic [7:0] cn, input logic r, input logic rdy, input logic clr);
        frame_stb = f; frame_addr = a; frame_cmd = c; frame_cmd_n = cn;
        rpt_stb = r; evt_ready = rdy; ovf_clr = clr;
        model_step(f, a, c, cn, r, rdy, clr);
        @(negedge clk_1m);
        compare_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic rdy);
        cycle(1'b1, MY_ADDR, c, ~c, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_rpt(input logic rdy);
        cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_1m);
        rst_n = 1'b0; frame_stb = 1'b0; rpt_stb = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk_1m);
        @(negedge clk_1m);
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_code", 32'(evt_code), 32'd0);
        check_eq("rst_type", 32'(evt_type), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_err", 32'(err_cnt), 32'd0);
        check_eq("rst_keydown", 32'(key_down), 32'd0);
        rst_n = 1'b1;
        model_reset();
        idle(1, 1'b0);
    endtask

    logic [7:0] r_code, r_cn, r_addr;
    logic       r_f, r_r, r_rdy, r_clr;
    int         rate;
    int         hold_lvl [8] = '{1, 1, 1, 2, 2, 3, 3, 4};
    int         err_before;

    initial begin
        model_reset();
        do_reset();

        // Press then silence: PRESS next cycle, RELEASE exactly T_OUT edges after the frame.
        send_frame(8'h45, 1'b0);
        check_eq("press45_level", 32'(fifo_level), 32'd1);
        check_eq("press45_code", 32'(evt_code), 32'h45);
        check_eq("press45_type", 32'(evt_type), 32'(E_PRESS));
        check_eq("press45_down", 32'(key_down), 32'd1);
        idle(T_OUT - 1, 1'b0);
        check_eq("pre_release_level", 32'(fifo_level), 32'd1);
        idle(1, 1'b0);
        check_eq("release45_level", 32'(fifo_level), 32'd2);
        check_eq("release45_down", 32'(key_down), 32'd0);
        idle(4, 1'b1);

        // Hold: HOLD on the 4th repeat, then every 2nd.
        send_frame(8'h16, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(269, 1'b0);
            send_rpt(1'b0);
            check_eq("hold_level", 32'(fifo_level), 32'(hold_lvl[i]));
        end
        idle(6, 1'b1);
        idle(T_OUT, 1'b1);

        // Key change with a repeat landing in the pending-press cycle.
        send_frame(8'h0C, 1'b0);
        idle(10, 1'b0);
        send_frame(8'h18, 1'b0);
        check_eq("change_rel_level", 32'(fifo_level), 32'd2);
        send_rpt(1'b0);
        check_eq("change_press_level", 32'(fifo_level), 32'd3);
        check_eq("change_head", 32'(evt_code), 32'h0C);
        idle(1, 1'b0);
        idle(5, 1'b1);

        // Command check failures saturate err_cnt.
        for (int i = 0; i < 300; i++) cycle(1'b1, MY_ADDR, 8'h45, 8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("err_saturated", 32'(err_cnt), 32'd255);
        idle(T_OUT + 5, 1'b1);

        // Overflow: five events into four slots, then full push+pop, clear, drain.
        send_frame(8'hA1, 1'b0); idle(3, 1'b0);
        send_frame(8'hA2, 1'b0); idle(3, 1'b0);
        send_frame(8'hA3, 1'b0); idle(3, 1'b0);
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        send_frame(8'hA4, 1'b1);
        idle(1, 1'b1);
        check_eq("full_pushpop_level", 32'(fifo_level), 32'd4);
        check_eq("full_pushpop_ovf", 32'(overflow), 32'd0);
        idle(6, 1'b1);
        check_eq("drained", 32'(evt_valid), 32'd0);
        idle(T_OUT + 5, 1'b1);

        // Random traffic in bursty and quiet blocks.
        for (int blk = 0; blk < 16; blk++) begin
            rate = (blk % 3 == 2) ? 0 : int'($urandom_range(5, 40));
            for (int i = 0; i < 500; i++) begin
                r_f    = ($urandom_range(0, 999) < rate);
                r_r    = ($urandom_range(0, 999) < rate);
                r_code = 8'h10 + 8'($urandom_range(0, 2));
                r_cn   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : ~r_code;
                r_addr = ($urandom_range(0, 7) == 0) ? 8'h01 : MY_ADDR;
                r_rdy  = ($urandom_range(0, 3) != 0);
                r_clr  = ($urandom_range(0, 63) == 0);
                cycle(r_f, r_addr, r_code, r_cn, r_r, r_rdy, r_clr);
            end
        end
        idle(T_OUT + 10, 1'b1);

        // Reset while holding: no RELEASE afterwards.
        send_frame(8'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(50, 1'b0);
            send_rpt(1'b0);
        end
        check_eq("hold_before_reset", 32'(key_down), 32'd1);
        do_reset();
        idle(T_OUT + 10, 1'b0);
        check_eq("no_release_after_reset", 32'(fifo_level), 32'd0);

        // Foreign address frame, valid and corrupt.
        err_before = int'(err_cnt);
        cycle(1'b1, 8'h01, 8'h33, ~8'h33, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        cycle(1'b1, 8'h01, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef IR_ADDR_FILTER_EN
        check_eq("filter_level", 32'(fifo_level), 32'd0);
        check_eq("filter_err", 32'(err_cnt), 32'(err_before));
`else
        check_eq("nofilter_level", 32'(fifo_level), 32'd1);
        check_eq("nofilter_err", 32'(err_cnt), 32'(err_before + 1));
`endif
        idle(T_OUT + 10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
